// File: rtl/netlist_seq.sv
// netlist_seq: netlist store and gate sequencer for the garbling engine.
// A circuit image arrives over a valid/ready load stream: four header words
// go to header registers, then one body word per DFF/gate goes to on-chip
// RAM. Once the body has been loaded, the body is replayed as decoded gate
// descriptors over a valid/ready stream, once per circuit clock cycle, for
// num_cc_i cycles.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start_i, abort_i         begin load (IDLE/ERR only), return to IDLE
//   num_cc_i                 cycle count latched on start (0 means 1)
//   load_data_i/valid_i      load stream in, load_ready_o back-pressure
//   gate_valid_o/ready_i     descriptor stream handshake
//   is_output_o, g_logic_o, in0_o, in1_o, in0f_o, in1f_o   descriptor fields
//   gate_idx_o, cc_idx_o, last_gate_o, last_cc_o           descriptor position
//   *_size_o                 decoded header
//   busy_o, done_o, err_o    status
module netlist_seq #(
  parameter int S  = 14,
  parameter int W  = 32,
  parameter int P  = 13,
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [CW-1:0] num_cc_i,
  input  logic [W-1:0]  load_data_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  output logic          gate_valid_o,
  input  logic          gate_ready_i,
  output logic          is_output_o,
  output logic [3:0]    g_logic_o,
  output logic [S-1:0]  in0_o,
  output logic [S-1:0]  in1_o,
  output logic          in0f_o,
  output logic          in1f_o,
  output logic [S-1:0]  gate_idx_o,
  output logic [CW-1:0] cc_idx_o,
  output logic          last_gate_o,
  output logic          last_cc_o,
  output logic [S-1:0]  init_size_o,
  output logic [S-1:0]  input_size_o,
  output logic [S-1:0]  dff_size_o,
  output logic [S-1:0]  output_size_o,
  output logic [S-1:0]  gate_size_o,
  output logic [S-1:0]  xor_size_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [2:0] {IDLE, LOAD_HDR, LOAD_BODY, STREAM, ERR} state_t;

  localparam logic [S:0] DEPTH = {1'b1, {S{1'b0}}};

  state_t state_q, state_d;

  logic [2*P-1:0] hdr_q [4];
  logic [1:0]     hcnt_q;
  logic [S-1:0]   wptr_q;
  logic [CW-1:0]  ncc_q;
  logic           err_q, done_q;

  logic [W-1:0]   mem [2**S];

  // Read side: rd_* is the next address to fetch, s1_* the RAM output
  // register (the single prefetch slot), out_* the presented descriptor.
  logic [S-1:0]   rd_idx_q;
  logic [CW-1:0]  rd_cc_q;
  logic           rd_more_q;
  logic [W-1:0]   s1_word_q;
  logic [S-1:0]   s1_idx_q;
  logic [CW-1:0]  s1_cc_q;
  logic           s1_valid_q;
  logic [W-1:0]   out_word_q;
  logic [S-1:0]   out_idx_q;
  logic [CW-1:0]  out_cc_q;
  logic           out_valid_q;

  logic [S:0]     body_cnt, body_last, in_thr;
  logic           body_ok, advance, s1_en, rd_en, rd_wrap, rd_last;
  logic           load_ready, hdr_we, mem_we, start_ack, err_set, accept_last;

  assign init_size_o   = S'(hdr_q[0][2*P-1:P]) + S'(hdr_q[0][P-1:0]);
  assign input_size_o  = S'(hdr_q[1][2*P-1:P]) + S'(hdr_q[1][P-1:0]);
  assign dff_size_o    = S'(hdr_q[2][2*P-1:P]);
  assign output_size_o = S'(hdr_q[2][P-1:0]);
  assign gate_size_o   = S'(hdr_q[3][P-1:0]);
  assign xor_size_o    = S'(hdr_q[3][2*P-1:P]);

  assign body_cnt  = {1'b0, dff_size_o} + {1'b0, gate_size_o};
  assign body_last = body_cnt - (S+1)'(1);
  assign body_ok   = (body_cnt != '0) && (body_cnt <= DEPTH);
  assign in_thr    = {1'b0, init_size_o} + {1'b0, input_size_o};

  // The output slot frees when empty or accepted; the prefetch slot refills
  // when it moves forward or is empty, so a stall holds exactly one extra word.
  assign advance = !out_valid_q || gate_ready_i;
  assign s1_en   = advance || !s1_valid_q;
  assign rd_en   = (state_q == STREAM) && !abort_i && s1_en && rd_more_q;
  assign rd_wrap = ({1'b0, rd_idx_q} == body_last);
  assign rd_last = rd_wrap && (rd_cc_q == ncc_q - CW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_ready  = 1'b0;
    hdr_we      = 1'b0;
    mem_we      = 1'b0;
    start_ack   = 1'b0;
    err_set     = 1'b0;
    accept_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = LOAD_HDR;
          start_ack = 1'b1;
        end
      end
      LOAD_HDR: begin
        load_ready = 1'b1;
        if (load_valid_i) begin
          hdr_we = 1'b1;
          if (hcnt_q == 2'd3) state_d = LOAD_BODY;
        end
      end
      LOAD_BODY: begin
        if (!body_ok) begin
          state_d = ERR;
          err_set = 1'b1;
        end else begin
          load_ready = 1'b1;
          if (load_valid_i) begin
            mem_we = 1'b1;
            if ({1'b0, wptr_q} == body_last) state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (out_valid_q && gate_ready_i && last_gate_o && last_cc_o) begin
          state_d     = IDLE;
          accept_last = 1'b1;
        end
      end
      ERR: begin
        if (start_i) begin
          state_d   = LOAD_HDR;
          start_ack = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything, including a simultaneous start
    if (abort_i) begin
      state_d     = IDLE;
      start_ack   = 1'b0;
      err_set     = 1'b0;
      accept_last = 1'b0;
      hdr_we      = 1'b0;
      mem_we      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) hdr_q[i] <= '0;
      hcnt_q      <= '0;
      wptr_q      <= '0;
      ncc_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rd_idx_q    <= '0;
      rd_cc_q     <= '0;
      rd_more_q   <= 1'b0;
      s1_idx_q    <= '0;
      s1_cc_q     <= '0;
      s1_valid_q  <= 1'b0;
      out_word_q  <= '0;
      out_idx_q   <= '0;
      out_cc_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      done_q <= accept_last;
      if (start_ack) begin
        err_q  <= 1'b0;
        hcnt_q <= '0;
        wptr_q <= '0;
        ncc_q  <= (num_cc_i == '0) ? CW'(1) : num_cc_i;
      end
      if (err_set) err_q <= 1'b1;
      if (hdr_we) begin
        hdr_q[hcnt_q] <= load_data_i[2*P-1:0];
        hcnt_q        <= hcnt_q + 2'd1;
      end
      if (mem_we) wptr_q <= wptr_q + S'(1);

      if (state_q != STREAM || abort_i) begin
        rd_idx_q    <= '0;
        rd_cc_q     <= '0;
        rd_more_q   <= 1'b1;
        s1_valid_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        if (advance) begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            out_word_q <= s1_word_q;
            out_idx_q  <= s1_idx_q;
            out_cc_q   <= s1_cc_q;
          end
        end
        if (s1_en) begin
          s1_valid_q <= rd_more_q;
          if (rd_more_q) begin
            s1_idx_q <= rd_idx_q;
            s1_cc_q  <= rd_cc_q;
            if (rd_wrap) begin
              rd_idx_q <= '0;
              rd_cc_q  <= rd_cc_q + CW'(1);
            end else begin
              rd_idx_q <= rd_idx_q + S'(1);
            end
            if (rd_last) rd_more_q <= 1'b0;
          end
        end
      end
    end
  end

  // Netlist RAM: no reset, registered read with enable so a stalled
  // prefetch word stays put.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wptr_q] <= load_data_i;
    if (rd_en)  s1_word_q   <= mem[rd_idx_q];
  end

  assign load_ready_o = load_ready;
  assign gate_valid_o = out_valid_q;
  assign is_output_o  = out_word_q[0];
  assign g_logic_o    = out_word_q[4:1];
  assign in1_o        = S'(out_word_q[P+4:5]);
  assign in0_o        = S'(out_word_q[W-1:P+5]);
  assign in0f_o       = ({1'b0, in0_o} < in_thr);
  assign in1f_o       = ({1'b0, in1_o} < in_thr);
  assign gate_idx_o   = out_idx_q;
  assign cc_idx_o     = out_cc_q;
  // position flags are qualified by valid so idle/reset outputs read 0
  assign last_gate_o  = out_valid_q && ({1'b0, out_idx_q} == body_last);
  assign last_cc_o    = out_valid_q && (out_cc_q == ncc_q - CW'(1));
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
